// File: rtl/alu_system_if.sv
// ----------------------------------------------------------------------------
// alu_system_if : control and observation bundle for the ALU system datapath
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_system_if;
  logic [2:0]  RF_O1Sel;
  logic [2:0]  RF_O2Sel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  RF_TSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  ARF_OutASel;
  logic [1:0]  ARF_OutBSel;
  logic [1:0]  ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        IR_LH;
  logic        IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [1:0]  MuxSelA;
  logic [1:0]  MuxSelB;
  logic        MuxCSel;

  logic [7:0]  Out1;
  logic [7:0]  Out2;
  logic [7:0]  ALUOut;
  logic [3:0]  ALUOutFlag;
  logic [7:0]  Address;
  logic [7:0]  MemoryOut;
  logic [15:0] IROut;
  logic [7:0]  MuxAOut;
  logic [7:0]  MuxBOut;
  logic [7:0]  MuxCOut;

  modport master (
    output RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RegSel, RF_TSel, ALU_FunSel,
           ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
           MuxSelA, MuxSelB, MuxCSel,
    input  Out1, Out2, ALUOut, ALUOutFlag, Address, MemoryOut, IROut,
           MuxAOut, MuxBOut, MuxCOut
  );

  modport slave (
    input  RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RegSel, RF_TSel, ALU_FunSel,
           ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
           MuxSelA, MuxSelB, MuxCSel,
    output Out1, Out2, ALUOut, ALUOutFlag, Address, MemoryOut, IROut,
           MuxAOut, MuxBOut, MuxCOut
  );
endinterface

`default_nettype wire

// File: rtl/alu_system.sv
// ----------------------------------------------------------------------------
// alu_system : register file, address register file, IR, ALU and 256x8 memory
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module alu_system (
  input logic        Clock,
  input logic        Reset,
  alu_system_if.slave bus
);

  // rf index 0-3 = T1-T4, 4-7 = R1-R4; arf index 0-3 = AR, SP, PCpast, PC
  logic [7:0]  rf_q  [8];
  logic [7:0]  rf_d  [8];
  logic [7:0]  arf_q [4];
  logic [7:0]  arf_d [4];
  logic [15:0] ir_q, ir_d;
  logic [3:0]  flag_q, flag_d;
  logic [7:0]  mem [256];

  logic [7:0]  out_a, alu_a, alu_b, alu_res, mem_rd, mux_a, mux_b;
  logic [8:0]  sum9;
  logic        c_new, o_new;
  logic [7:0]  rf_en;
  logic [3:0]  arf_en;

  function automatic logic [7:0] step8(input logic [1:0] fs, input logic [7:0] cur,
                                       input logic [7:0] din);
    case (fs)
      2'b00:   step8 = 8'h00;
      2'b01:   step8 = din;
      2'b10:   step8 = cur - 8'd1;
      default: step8 = cur + 8'd1;
    endcase
  endfunction

  assign bus.Out1    = rf_q[bus.RF_O1Sel];
  assign bus.Out2    = rf_q[bus.RF_O2Sel];
  assign out_a       = arf_q[bus.ARF_OutASel];
  assign bus.Address = arf_q[bus.ARF_OutBSel];
  assign alu_a       = bus.MuxCSel ? out_a : rf_q[bus.RF_O1Sel];
  assign alu_b       = rf_q[bus.RF_O2Sel];
  assign bus.MuxCOut = alu_a;

  always_comb begin
    sum9    = 9'd0;
    alu_res = alu_a;
    c_new   = flag_q[2];
    o_new   = flag_q[0];
    case (bus.ALU_FunSel)
      4'h0: alu_res = alu_a;
      4'h1: alu_res = alu_b;
      4'h2: alu_res = ~alu_a;
      4'h3: alu_res = ~alu_b;
      4'h4, 4'h5: begin
        sum9    = {1'b0, alu_a} + {1'b0, alu_b} +
                  {8'd0, (bus.ALU_FunSel == 4'h5) & flag_q[2]};
        alu_res = sum9[7:0];
        c_new   = sum9[8];
        o_new   = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
      end
      4'h6: begin
        sum9    = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
        alu_res = sum9[7:0];
        c_new   = sum9[8];
        o_new   = (alu_a[7] != alu_b[7]) && (sum9[7] != alu_a[7]);
      end
      4'h7: alu_res = alu_a & alu_b;
      4'h8: alu_res = alu_a | alu_b;
      4'h9: alu_res = alu_a ^ alu_b;
      4'hA: begin alu_res = {alu_a[6:0], 1'b0};     c_new = alu_a[7]; end
      4'hB: begin alu_res = {1'b0, alu_a[7:1]};     c_new = alu_a[0]; end
      4'hC: begin
        alu_res = {alu_a[6:0], 1'b0};
        c_new   = alu_a[7];
        o_new   = alu_a[7] ^ alu_a[6];
      end
      4'hD: begin alu_res = {alu_a[7], alu_a[7:1]}; c_new = alu_a[0]; end
      4'hE: begin alu_res = {alu_a[6:0], flag_q[2]}; c_new = alu_a[7]; end
      default: begin alu_res = {flag_q[2], alu_a[7:1]}; c_new = alu_a[0]; end
    endcase
    flag_d = {alu_res == 8'h00, c_new, alu_res[7], o_new};
  end

  assign bus.ALUOut     = alu_res;
  assign bus.ALUOutFlag = flag_q;
  assign bus.IROut      = ir_q;

  assign mem_rd        = (!bus.Mem_CS && !bus.Mem_WR) ? mem[bus.Address] : 8'h00;
  assign bus.MemoryOut = mem_rd;

  always_comb begin
    case (bus.MuxSelA)
      2'b00:   mux_a = alu_res;
      2'b01:   mux_a = mem_rd;
      2'b10:   mux_a = ir_q[7:0];
      default: mux_a = out_a;
    endcase
    case (bus.MuxSelB)
      2'b00:   mux_b = alu_res;
      2'b01:   mux_b = mem_rd;
      2'b10:   mux_b = ir_q[7:0];
      default: mux_b = out_a;
    endcase
  end

  assign bus.MuxAOut = mux_a;
  assign bus.MuxBOut = mux_b;

  // Enable vectors reordered so bit i gates storage index i
  assign rf_en  = {bus.RF_RegSel[0], bus.RF_RegSel[1], bus.RF_RegSel[2], bus.RF_RegSel[3],
                   bus.RF_TSel[0],   bus.RF_TSel[1],   bus.RF_TSel[2],   bus.RF_TSel[3]};
  assign arf_en = {bus.ARF_RegSel[3], bus.ARF_RegSel[0], bus.ARF_RegSel[1], bus.ARF_RegSel[2]};

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rf_d[i] = rf_en[i] ? step8(bus.RF_FunSel, rf_q[i], mux_a) : rf_q[i];
    end
    for (int i = 0; i < 4; i++) begin
      arf_d[i] = arf_en[i] ? step8(bus.ARF_FunSel, arf_q[i], mux_b) : arf_q[i];
    end
    ir_d = ir_q;
    if (bus.IR_Enable) begin
      case (bus.IR_Funsel)
        2'b00:   ir_d = 16'h0000;
        2'b01:   ir_d = bus.IR_LH ? {mem_rd, ir_q[7:0]} : {ir_q[15:8], mem_rd};
        2'b10:   ir_d = ir_q - 16'd1;
        default: ir_d = ir_q + 16'd1;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < 8; i++) rf_q[i]  <= 8'h00;
      for (int i = 0; i < 4; i++) arf_q[i] <= 8'h00;
      ir_q   <= 16'h0000;
      flag_q <= 4'h0;
    end else begin
      for (int i = 0; i < 8; i++) rf_q[i]  <= rf_d[i];
      for (int i = 0; i < 4; i++) arf_q[i] <= arf_d[i];
      ir_q   <= ir_d;
      flag_q <= flag_d;
    end
  end

  // Memory is never cleared and ignores writes while reset is asserted
  always_ff @(posedge Clock) begin
    if (Reset && !bus.Mem_CS && bus.Mem_WR) begin
      mem[bus.Address] <= alu_res;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_system.sv
// ----------------------------------------------------------------------------
// tb_alu_system : directed and random stimulus against a reference model
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_system;

  logic Clock;
  logic Reset;

  alu_system_if ifc ();

  alu_system dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (ifc)
  );

  typedef struct {
    logic [2:0] o1, o2;
    logic [1:0] rffun;
    logic [3:0] rreg, tsel, alufun;
    logic [1:0] aA, aB, afun;
    logic [3:0] areg;
    logic       lh, iren;
    logic [1:0] irfun;
    logic       wr, cs;
    logic [1:0] ma, mb;
    logic       mc;
    logic       rst_n;
  } ctrl_t;

  typedef struct {
    logic [7:0]  out1, out2, alu, addr, memout, muxa, muxb, muxc;
    logic [3:0]  flags;
    logic [15:0] ir;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference state: rf 0-3 T1-T4, 4-7 R1-R4; arf 0-3 AR, SP, PCpast, PC
  int m_rf  [8];
  int m_arf [4];
  int m_ir;
  int m_z, m_c, m_n, m_o;
  int m_mem [256];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic void alu_ref(input int op, input int a, input int b, input int cf,
                                  input int oold, output int r, output int c, output int o);
    int s;
    c = cf;
    o = oold;
    r = 0;
    case (op)
      0: r = a;
      1: r = b;
      2: r = 255 - a;
      3: r = 255 - b;
      4, 5: begin
        s = a + b + ((op == 5) ? cf : 0);
        r = s % 256; c = s / 256;
        o = ((a < 128) == (b < 128) && (r < 128) != (a < 128)) ? 1 : 0;
      end
      6: begin
        s = a + (255 - b) + 1;
        r = s % 256; c = s / 256;
        o = ((a < 128) != (b < 128) && (r < 128) != (a < 128)) ? 1 : 0;
      end
      7: r = a & b;
      8: r = a | b;
      9: r = a ^ b;
      10: begin r = (a * 2) % 256; c = a / 128; end
      11: begin r = a / 2; c = a % 2; end
      12: begin r = (a * 2) % 256; c = a / 128; o = ((a / 128) % 2 != (a / 64) % 2) ? 1 : 0; end
      13: begin r = a / 2 + (a / 128) * 128; c = a % 2; end
      14: begin r = (a * 2) % 256 + cf; c = a / 128; end
      default: begin r = a / 2 + cf * 128; c = a % 2; end
    endcase
  endfunction

  function automatic int regop(input int fun, input int cur, input int din, input int modulo);
    case (fun)
      0: return 0;
      1: return din;
      2: return (cur + modulo - 1) % modulo;
      default: return (cur + 1) % modulo;
    endcase
  endfunction

  function automatic int pick(input int s, input int alu, input int md, input int irlo,
                              input int oa);
    case (s)
      0: return alu;
      1: return md;
      2: return irlo;
      default: return oa;
    endcase
  endfunction

  function automatic ctrl_t idle();
    ctrl_t c;
    c.o1 = 3'd0; c.o2 = 3'd0; c.rffun = 2'd0; c.rreg = 4'd0; c.tsel = 4'd0;
    c.alufun = 4'd0; c.aA = 2'd0; c.aB = 2'd0; c.afun = 2'd0; c.areg = 4'd0;
    c.lh = 1'b0; c.iren = 1'b0; c.irfun = 2'd0; c.wr = 1'b0; c.cs = 1'b1;
    c.ma = 2'd0; c.mb = 2'd0; c.mc = 1'b0; c.rst_n = 1'b1;
    return c;
  endfunction

  task automatic drive(input ctrl_t c);
    ifc.RF_O1Sel = c.o1;      ifc.RF_O2Sel = c.o2;     ifc.RF_FunSel = c.rffun;
    ifc.RF_RegSel = c.rreg;   ifc.RF_TSel = c.tsel;    ifc.ALU_FunSel = c.alufun;
    ifc.ARF_OutASel = c.aA;   ifc.ARF_OutBSel = c.aB;  ifc.ARF_FunSel = c.afun;
    ifc.ARF_RegSel = c.areg;  ifc.IR_LH = c.lh;        ifc.IR_Enable = c.iren;
    ifc.IR_Funsel = c.irfun;  ifc.Mem_WR = c.wr;       ifc.Mem_CS = c.cs;
    ifc.MuxSelA = c.ma;       ifc.MuxSelB = c.mb;      ifc.MuxCSel = c.mc;
    Reset = c.rst_n;
  endtask

  // One clock: apply controls, queue the expected view, advance the model
  task automatic cycle(input ctrl_t c, input bit chk);
    exp_t e;
    int o1, o2, oa, adr, ain, r, cn, on, md, va, vb;
    int abit [4];
    abit = '{2, 1, 0, 3};
    @(posedge Clock);
    #1;
    drive(c);
    o1  = m_rf[c.o1];
    o2  = m_rf[c.o2];
    oa  = m_arf[c.aA];
    adr = m_arf[c.aB];
    ain = c.mc ? oa : o1;
    alu_ref(int'(c.alufun), ain, o2, m_c, m_o, r, cn, on);
    md  = (!c.cs && !c.wr) ? m_mem[adr] : 0;
    va  = pick(int'(c.ma), r, md, m_ir % 256, oa);
    vb  = pick(int'(c.mb), r, md, m_ir % 256, oa);
    e.out1 = 8'(o1);   e.out2 = 8'(o2);   e.alu = 8'(r);     e.addr = 8'(adr);
    e.memout = 8'(md); e.muxa = 8'(va);   e.muxb = 8'(vb);   e.muxc = 8'(ain);
    e.flags = 4'(m_z * 8 + m_c * 4 + m_n * 2 + m_o);
    e.ir = 16'(m_ir);
    if (chk) q.push_back(e);
    if (!c.rst_n) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 0;
      for (int i = 0; i < 4; i++) m_arf[i] = 0;
      m_ir = 0; m_z = 0; m_c = 0; m_n = 0; m_o = 0;
    end else begin
      for (int i = 0; i < 8; i++)
        if ((i < 4) ? c.tsel[3 - i] : c.rreg[7 - i])
          m_rf[i] = regop(int'(c.rffun), m_rf[i], va, 256);
      for (int i = 0; i < 4; i++)
        if (c.areg[abit[i]]) m_arf[i] = regop(int'(c.afun), m_arf[i], vb, 256);
      if (c.iren) begin
        if (c.irfun == 2'd1)
          m_ir = c.lh ? (md * 256 + m_ir % 256) : ((m_ir / 256) * 256 + md);
        else
          m_ir = regop(int'(c.irfun), m_ir, 0, 65536);
      end
      if (!c.cs && c.wr) m_mem[adr] = r;
      m_z = (r == 0) ? 1 : 0;
      m_c = cn;
      m_n = (r >= 128) ? 1 : 0;
      m_o = on;
    end
    #2;
  endtask

  task automatic ar_steps(input int n, input logic [1:0] fun);
    ctrl_t c;
    c = idle();
    c.areg = 4'b0100;
    c.afun = fun;
    for (int i = 0; i < n; i++) cycle(c, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("out1",   {8'h00, ifc.Out1},      {8'h00, e.out1});
        cmp("out2",   {8'h00, ifc.Out2},      {8'h00, e.out2});
        cmp("aluout", {8'h00, ifc.ALUOut},    {8'h00, e.alu});
        cmp("flags",  {12'h000, ifc.ALUOutFlag}, {12'h000, e.flags});
        cmp("addr",   {8'h00, ifc.Address},   {8'h00, e.addr});
        cmp("memout", {8'h00, ifc.MemoryOut}, {8'h00, e.memout});
        cmp("irout",  ifc.IROut,              e.ir);
        cmp("muxa",   {8'h00, ifc.MuxAOut},   {8'h00, e.muxa});
        cmp("muxb",   {8'h00, ifc.MuxBOut},   {8'h00, e.muxb});
        cmp("muxc",   {8'h00, ifc.MuxCOut},   {8'h00, e.muxc});
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    ctrl_t c;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    for (int i = 0; i < 4; i++) m_arf[i] = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = 0;
    m_ir = 0; m_z = 0; m_c = 0; m_n = 0; m_o = 0;

    c = idle(); c.rst_n = 1'b0;
    drive(c);
    cycle(c, 1'b0);

    // Fill memory with mem[a] = a by walking AR and writing ALUOut = AR
    c = idle(); c.cs = 1'b0; c.wr = 1'b1; c.mc = 1'b1; c.areg = 4'b0100; c.afun = 2'b11;
    for (int i = 0; i < 256; i++) cycle(c, 1'b1);

    c = idle(); c.rst_n = 1'b0; cycle(c, 1'b1);

    // R1 wraps on increment and decrement
    c = idle(); c.o1 = 3'd4; c.alufun = 4'h2; c.rreg = 4'b1000; c.rffun = 2'b01; cycle(c, 1'b1);
    c = idle(); c.o1 = 3'd4; c.rreg = 4'b1000; c.rffun = 2'b11; cycle(c, 1'b1);
    cmp("r1_load_ff", {8'h00, ifc.Out1}, 16'h00FF);
    c = idle(); c.o1 = 3'd4; c.rreg = 4'b1000; c.rffun = 2'b10; cycle(c, 1'b1);
    cmp("r1_inc_wrap", {8'h00, ifc.Out1}, 16'h0000);
    c = idle(); c.o1 = 3'd4; cycle(c, 1'b1);
    cmp("r1_dec_wrap", {8'h00, ifc.Out1}, 16'h00FF);

    // 0x7F + 0x01 signed overflow
    c = idle(); c.o1 = 3'd1; c.alufun = 4'h2; c.tsel = 4'b1000; c.rffun = 2'b01; cycle(c, 1'b1);
    c = idle(); c.o1 = 3'd0; c.alufun = 4'hB; c.tsel = 4'b1000; c.rffun = 2'b01; cycle(c, 1'b1);
    c = idle(); c.tsel = 4'b0100; c.rffun = 2'b11; cycle(c, 1'b1);
    c = idle(); c.o1 = 3'd0; c.o2 = 3'd1; c.alufun = 4'h4; cycle(c, 1'b1);
    cmp("add_result", {8'h00, ifc.ALUOut}, 16'h0080);
    c = idle(); cycle(c, 1'b1);
    cmp("add_flags", {12'h000, ifc.ALUOutFlag}, 16'h0003);

    // 5 - 5
    c = idle(); c.tsel = 4'b0100; c.rffun = 2'b11;
    for (int i = 0; i < 4; i++) cycle(c, 1'b1);
    c = idle(); c.o2 = 3'd1; c.alufun = 4'h1; c.tsel = 4'b1000; c.rffun = 2'b01; cycle(c, 1'b1);
    c = idle(); c.o1 = 3'd0; c.o2 = 3'd1; c.alufun = 4'h6; cycle(c, 1'b1);
    cmp("sub_result", {8'h00, ifc.ALUOut}, 16'h0000);
    c = idle(); cycle(c, 1'b1);
    cmp("sub_flags", {12'h000, ifc.ALUOutFlag}, 16'h000C);

    // PC = 0x12 through the ALU, then into R1 through MuxA's ARF path
    ar_steps(18, 2'b11);
    c = idle(); c.mc = 1'b1; c.areg = 4'b1000; c.afun = 2'b01; cycle(c, 1'b1);
    c = idle(); c.aA = 2'b11; c.ma = 2'b11; c.rreg = 4'b1000; c.rffun = 2'b01; cycle(c, 1'b1);
    cmp("muxa_arf", {8'h00, ifc.MuxAOut}, 16'h0012);
    c = idle(); c.o1 = 3'd4; cycle(c, 1'b1);
    cmp("r1_from_pc", {8'h00, ifc.Out1}, 16'h0012);

    // Memory survives reset
    ar_steps(42, 2'b11);
    c = idle(); c.mc = 1'b1; c.tsel = 4'b1000; c.rffun = 2'b01; cycle(c, 1'b1);
    ar_steps(44, 2'b10);
    c = idle(); c.cs = 1'b0; c.wr = 1'b1; cycle(c, 1'b1);
    cmp("wr_addr", {8'h00, ifc.Address}, 16'h0010);
    c = idle(); c.rst_n = 1'b0; c.tsel = 4'b1111; c.rffun = 2'b11; cycle(c, 1'b1);
    c = idle(); c.o2 = 3'd4; cycle(c, 1'b1);
    cmp("rst_t1", {8'h00, ifc.Out1}, 16'h0000);
    cmp("rst_r1", {8'h00, ifc.Out2}, 16'h0000);
    cmp("rst_addr", {8'h00, ifc.Address}, 16'h0000);
    cmp("rst_ir", ifc.IROut, 16'h0000);
    cmp("rst_flags", {12'h000, ifc.ALUOutFlag}, 16'h0000);
    ar_steps(16, 2'b11);
    c = idle(); c.cs = 1'b0; c.wr = 1'b0; cycle(c, 1'b1);
    cmp("mem_kept", {8'h00, ifc.MemoryOut}, 16'h003C);

    // IR byte loads from memory at 0xAA then 0x55
    ar_steps(154, 2'b11);
    c = idle(); c.cs = 1'b0; c.iren = 1'b1; c.irfun = 2'b01; c.lh = 1'b1; cycle(c, 1'b1);
    ar_steps(85, 2'b10);
    c = idle(); c.cs = 1'b0; c.iren = 1'b1; c.irfun = 2'b01; c.lh = 1'b0; cycle(c, 1'b1);
    c = idle(); cycle(c, 1'b1);
    cmp("ir_bytes", ifc.IROut, 16'hAA55);

    for (int n = 0; n < 3000; n++) begin
      c.o1 = 3'($urandom());     c.o2 = 3'($urandom());     c.rffun = 2'($urandom());
      c.rreg = 4'($urandom());   c.tsel = 4'($urandom());   c.alufun = 4'($urandom());
      c.aA = 2'($urandom());     c.aB = 2'($urandom());     c.afun = 2'($urandom());
      c.areg = 4'($urandom());   c.lh = 1'($urandom());     c.iren = 1'($urandom());
      c.irfun = 2'($urandom());  c.wr = 1'($urandom());     c.cs = 1'($urandom());
      c.ma = 2'($urandom());     c.mb = 2'($urandom());     c.mc = 1'($urandom());
      c.rst_n = ($urandom_range(0, 31) != 0);
      cycle(c, 1'b1);
    end

    @(negedge Clock);
    #1;
    cmp("queue_drained", 16'(q.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
